// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: arbitrates jump/multi-cycle/hold
// requests and drives PC, IF/ID and ID/EX stall and flush controls.
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jump_en_i,
   input  logic [31:0]      jump_addr_i,
   input  logic             hold_ex_i,
   input  logic             hold_bus_i,
   input  logic             mc_start_i,
   input  logic [CNT_W-1:0] mc_cycles_i,
   output logic             jump_en_o,
   output logic [31:0]      jump_addr_o,
   output logic [2:0]       stall_o,
   output logic [1:0]       flush_o,
   output logic             mc_done_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      MC_WAIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mc_done_q, mc_done_d;

   // State, shared countdown and the registered done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         cnt_q     <= CNT_ZERO;
         mc_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mc_done_q <= mc_done_d;
      end
   end

   // Next-state decode and combinational control outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mc_done_d   = 1'b0;
      jump_en_o   = 1'b0;
      jump_addr_o = 32'h0000_0000;
      stall_o     = 3'b000;
      flush_o     = 2'b00;

      if (rst) begin
         state_d = RUN;
         cnt_d   = CNT_ZERO;
      end else begin
         case (state_q)
            RUN: begin
               // Fixed priority; a zero-length multi-cycle request falls through.
               if (jump_en_i) begin
                  jump_en_o   = 1'b1;
                  jump_addr_o = jump_addr_i;
                  flush_o     = 2'b11;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                     cnt_d   = FLUSH_CNT;
                  end else begin
                     state_d = RUN;
                  end
               end else if (mc_start_i && (mc_cycles_i != CNT_ZERO)) begin
                  stall_o = 3'b111;
                  if (mc_cycles_i > CNT_ONE) begin
                     state_d = MC_WAIT;
                     cnt_d   = mc_cycles_i - CNT_ONE;
                  end else begin
                     mc_done_d = 1'b1;
                  end
               end else if (hold_ex_i) begin
                  stall_o = 3'b111;
               end else if (hold_bus_i) begin
                  stall_o = 3'b011;
                  flush_o = 2'b10;
               end else begin
                  state_d = RUN;
               end
            end
            FLUSH: begin
               flush_o = 2'b11;
               if (hold_bus_i) begin
                  stall_o = 3'b001;
               end else if (cnt_q <= CNT_ONE) begin
                  state_d = RUN;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            MC_WAIT: begin
               stall_o = 3'b111;
               if (cnt_q <= CNT_ONE) begin
                  state_d   = RUN;
                  cnt_d     = CNT_ZERO;
                  mc_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   assign mc_done_o = mc_done_q;
   assign busy_o    = (state_q != RUN);

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage RISC-V core; receives redirect/hold requests from the execute stage and the instruction bus, and sequences PC, IF/ID and ID/EX register control. Owns the post-jump flush window and the countdown for multi-cycle EX operations such as mul/div. Arbitrates between simultaneous requests with fixed priority.

## Interface
Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays high after a taken jump, counting the request cycle; legal range 1..2^CNT_W-1
- CNT_W, 6, width of the shared down-counter and of mc_cycles_i

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- jump_en_i  in  1  taken branch/jump from EX
- jump_addr_i  in  32  redirect target from EX
- hold_ex_i  in  1  level stall request from EX
- hold_bus_i  in  1  instruction-bus wait, level
- mc_start_i  in  1  one-cycle start pulse for a multi-cycle EX op
- mc_cycles_i  in  CNT_W  total stall cycles for that op, N
- jump_en_o  out  1  PC load enable
- jump_addr_o  out  32  PC load value
- stall_o  out  3  hold enables: [0] PC, [1] IF/ID, [2] ID/EX
- flush_o  out  2  bubble insert: [0] IF/ID, [1] ID/EX
- mc_done_o  out  1  one-cycle pulse; EX captures the multi-cycle result
- busy_o  out  1  high when the state is not RUN

## Operation
- States: RUN, FLUSH, MC_WAIT. A CNT_W-bit counter cnt is shared by FLUSH and MC_WAIT.
- RUN decode uses fixed priority: jump_en_i, then mc_start_i, then hold_ex_i, then hold_bus_i.
  - jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, flush_o=11. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1. Otherwise stay in RUN. A coincident mc_start_i is dropped.
  - mc_start_i with N≥1: stall_o=111. If N>1, go to MC_WAIT with cnt=N-1. If N=1, stay in RUN and pulse mc_done_o the next cycle. If N=0, ignore the request and assert no stall.
  - hold_ex_i: stall_o=111.
  - hold_bus_i: stall_o=011, flush_o=10.
- FLUSH:
  - flush_o=11 every cycle.
  - If hold_bus_i=1, stall_o=001 and cnt holds.
  - Otherwise cnt decrements. When cnt==1 and hold_bus_i=0, return to RUN.
  - jump_en_i, hold_ex_i and mc_start_i are ignored in this state.
- MC_WAIT:
  - stall_o=111 and cnt decrements every cycle.
  - When cnt==1, return to RUN and register mc_done_o=1 for the next cycle.
  - All other inputs are ignored.
- Default output value is 0 for every output, including jump_addr_o=0 whenever jump_en_o=0.
- busy_o = (state != RUN).

## Timing
- Outputs are combinational from the registered state/cnt and the current inputs. Only state, cnt and mc_done_o are registered.
- While rst=1, all outputs are 0, state=RUN and cnt=0. Reset assertion mid-FLUSH or mid-MC_WAIT aborts the operation immediately, with no mc_done_o pulse.
- Jump latency: jump_en_o is asserted in the same cycle as jump_en_i, and the PC loads on the next edge. For a jump in cycle t, flush_o is high in cycles t..t+FLUSH_CYCLES-1, extended by the number of hold_bus_i cycles that occur inside FLUSH.
- Multi-cycle op: a request in cycle t with N stalls cycles t..t+N-1. mc_done_o is high in cycle t+N only, and stall_o=000 in t+N unless a new request arrives.
- cnt never underflows. Transitions out of FLUSH and MC_WAIT are taken at cnt==1.
- A new request is accepted in the first RUN cycle after FLUSH or MC_WAIT, including the mc_done_o cycle.

## Test plan
- Reset: rst=1 with all inputs driven high -> every output 0 and busy_o=0. Release rst with inputs low -> outputs stay 0.
- Jump with FLUSH_CYCLES=2: jump_en_i=1, jump_addr_i=0x0000_0100 at t -> jump_en_o=1, addr 0x100 and flush_o=11 at t; flush_o=11 and busy_o=1 at t+1; all outputs 0 at t+2. A second jump_en_i at t+1 is ignored.
- Multi-cycle N=4 at t -> stall_o=111 at t..t+3, mc_done_o=1 only at t+4. N=1 -> stall at t only and mc_done_o at t+1. N=0 -> no stall and no done pulse.
- Priority: jump_en_i, mc_start_i (N=3) and hold_ex_i all high at t -> jump wins, flush_o=11 and stall_o=000, and no mc_done_o appears afterwards. hold_ex_i and hold_bus_i together -> stall_o=111, flush_o=00.
- Bus wait inside FLUSH: jump at t, hold_bus_i high at t+1..t+2 -> stall_o=001 and flush_o=11 at t+1..t+2, flush_o=11 at t+3, back in RUN at t+4.
- Reset mid-MC_WAIT: N=10, rst pulsed at t+3 -> outputs 0 immediately, RUN after release, and no mc_done_o pulse.
